// File: rtl/lsu_defs.sv
// Shared definitions for the load/store controller: funct3 codes, access
// widths and the controller state encoding.
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int SIZE_B = 8;
  localparam int SIZE_H = 16;
  localparam int SIZE_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge,
// and illegal/misaligned access detection.
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic        err
);

  logic [SIZE_B-1:0] b;
  logic [SIZE_H-1:0] h;
  logic              illegal;
  logic              misalign;

  always_comb begin
    b          = word[{addr_lo, 3'b000} +: SIZE_B];
    h          = word[{addr_lo[1], 4'b0000} +: SIZE_H];
    load_val   = '0;
    store_word = word;
    illegal    = 1'b0;
    misalign   = 1'b0;
    case (funct3)
      F3_B: begin
        load_val = {{(SIZE_W-SIZE_B){b[SIZE_B-1]}}, b};
        store_word[{addr_lo, 3'b000} +: SIZE_B] = wdata[SIZE_B-1:0];
      end
      F3_H: begin
        load_val = {{(SIZE_W-SIZE_H){h[SIZE_H-1]}}, h};
        store_word[{addr_lo[1], 4'b0000} +: SIZE_H] = wdata[SIZE_H-1:0];
        misalign = addr_lo[0];
      end
      F3_W: begin
        load_val   = word;
        store_word = wdata;
        misalign   = |addr_lo;
      end
      // Unsigned variants exist only for loads
      F3_BU: begin
        load_val = {{(SIZE_W-SIZE_B){1'b0}}, b};
        illegal  = is_store;
      end
      F3_HU: begin
        load_val = {{(SIZE_W-SIZE_H){1'b0}}, h};
        illegal  = is_store;
        misalign = addr_lo[0];
      end
      default: illegal = 1'b1;
    endcase
    err = illegal | misalign;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller between the core data port and a word-only data_mem.
// Sub-word stores are done as read-modify-write.
module data_mem_ctrl
  import lsu_defs::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [1:0] LAT = 2'(MEM_RD_LAT);

  state_t            state, state_nx;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q, word_q, result_q;
  logic [1:0]        cnt;

  logic              idle, accept, rd_phase, cap;
  logic [2:0]        al_f3;
  logic [1:0]        al_lo;
  logic              al_store, al_err;
  logic [31:0]       al_word, load_val, store_word;

  assign idle     = (state == S_IDLE);
  assign accept   = idle & req_i;
  assign rd_phase = (state == S_RD) || (state == S_RMW_RD);
  assign cap      = rd_phase && (cnt == LAT);
  assign busy_o   = ~idle;

  // In IDLE the lane logic classifies the incoming request; afterwards it
  // works on the latched request.
  assign al_f3    = idle ? funct3_i    : f3_q;
  assign al_lo    = idle ? addr_i[1:0] : addr_q[1:0];
  assign al_store = idle ? we_i        : we_q;
  assign al_word  = (state == S_WR) ? word_q : mem_rdata_i;

  lsu_lane_align u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .is_store   (al_store),
    .word       (al_word),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word),
    .err        (al_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      result_q <= '0;
      cnt      <= '0;
    end else begin
      cnt <= rd_phase ? cnt + 2'd1 : 2'd0;
      if (accept) begin
        we_q     <= we_i;
        f3_q     <= funct3_i;
        addr_q   <= addr_i;
        wdata_q  <= wdata_i;
        err_q    <= al_err;
        result_q <= '0;
      end
      if (cap) begin
        word_q   <= mem_rdata_i;
        result_q <= we_q ? '0 : load_val;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    ready_o     = 1'b0;
    err_o       = 1'b0;
    rdata_o     = '0;
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      S_IDLE: begin
        if (req_i) begin
          if (al_err)              state_nx = S_RESP;
          else if (!we_i)          state_nx = S_RD;
          else if (funct3_i == F3_W) state_nx = S_WR;
          else                     state_nx = S_RMW_RD;
        end
      end
      S_RD, S_RMW_RD: begin
        mem_ce_o   = 1'b1;
        mem_addr_o = {addr_q[31:2], 2'b00};
        if (cap) state_nx = (state == S_RD) ? S_RESP : S_WR;
      end
      S_WR: begin
        mem_ce_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wdata_o = store_word;
        state_nx    = S_RESP;
      end
      S_RESP: begin
        ready_o  = 1'b1;
        err_o    = err_q;
        rdata_o  = result_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with a one-cycle-latency word memory.
module tb_data_mem_ctrl;
  import lsu_defs::*;

  logic        clk, rst, req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        ready_o, err_o, busy_o, mem_ce_o, mem_we_o;

  data_mem_ctrl #(.MEM_RD_LAT(1), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ready_o(ready_o),
    .err_o(err_o), .busy_o(busy_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  logic        poke;
  logic [3:0]  poke_idx;
  logic [31:0] poke_data;

  always @(posedge clk) begin
    if (mem_ce_o && !mem_we_o) mem_rdata_i <= mem[mem_addr_o[5:2]];
    if (mem_ce_o && mem_we_o)  mem[mem_addr_o[5:2]] <= mem_wdata_o;
    if (poke)                  mem[poke_idx] <= poke_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t;
  } exp_t;
  exp_t q[$];

  int nvec = 0, nerr = 0;
  int nce = 0, nwr = 0, nrdy = 0;
  logic [31:0] last_wa = '0, last_wd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: counts memory activity and checks every ready pulse
  always @(negedge clk) begin
    if (rst) begin
      if (mem_ce_o) nce++;
      if (mem_ce_o && mem_we_o) begin
        nwr++;
        last_wa = mem_addr_o;
        last_wd = mem_wdata_o;
      end
      if (ready_o) begin
        nrdy++;
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_ready: got ready_o=1 expected no response");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.nm, "_rdata"}, rdata_o, e.rdata);
          chk({e.nm, "_err"}, 32'(err_o), 32'(e.err));
          chk({e.nm, "_lat"}, 32'(cyc - e.t), 32'(e.lat));
          chk({e.nm, "_ce_in_resp"}, 32'(mem_ce_o), 32'd0);
        end
      end
    end
  end

  task automatic do_poke(input logic [3:0] idx, input logic [31:0] d);
    poke = 1'b1; poke_idx = idx; poke_data = d;
    @(negedge clk);
    poke = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 50) begin @(negedge clk); n++; end
    if (busy_o) begin
      nvec++; nerr++;
      $display("FAIL idle_timeout: got busy_o=1 expected 0");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL resp_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_i = 1'b1; we_i = w; funct3_i = f3; addr_i = a; wdata_i = wd;
  endtask

  task automatic issue(input string nm, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err, input int lat);
    wait_idle();
    q.push_back('{nm, exp_rd, exp_err, lat, cyc});
    drive(w, f3, a, wd);
    @(negedge clk);
    req_i = 1'b0;
    wait_drain();
  endtask

  int w0, c0, r0;

  initial begin
    rst = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
    poke = 1'b0; poke_idx = '0; poke_data = '0;
    @(negedge clk);
    do_poke(4'd4, 32'h8000_7F80);
    do_poke(4'd5, 32'h0);
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ce", 32'(mem_ce_o), 0);
    chk("rst_rdata", rdata_o, 0);
    rst = 1'b1;
    @(negedge clk);

    // Loads with extension
    w0 = nwr;
    issue("lb10",  0, F3_B,  32'h10, 0, 32'hFFFF_FF80, 0, 3);
    issue("lbu10", 0, F3_BU, 32'h10, 0, 32'h0000_0080, 0, 3);
    issue("lb11",  0, F3_B,  32'h11, 0, 32'h0000_007F, 0, 3);
    issue("lh12",  0, F3_H,  32'h12, 0, 32'hFFFF_8000, 0, 3);
    issue("lhu12", 0, F3_HU, 32'h12, 0, 32'h0000_8000, 0, 3);
    issue("lw10",  0, F3_W,  32'h10, 0, 32'h8000_7F80, 0, 3);
    chk("loads_no_write", 32'(nwr - w0), 0);

    // Sub-word stores via read-modify-write
    w0 = nwr;
    issue("sb11", 1, F3_B, 32'h11, 32'h1234_56AB, 0, 0, 4);
    chk("sb11_nwr", 32'(nwr - w0), 1);
    chk("sb11_wa", last_wa, 32'h10);
    chk("sb11_wd", last_wd, 32'h8000_AB80);
    issue("sh12", 1, F3_H, 32'h12, 32'h0000_CAFE, 0, 0, 4);
    chk("sh12_wd", last_wd, 32'hCAFE_AB80);
    chk("sh12_mem", mem[4], 32'hCAFE_AB80);
    issue("lw10b", 0, F3_W, 32'h10, 0, 32'hCAFE_AB80, 0, 3);

    // Full-word store
    issue("sw14", 1, F3_W, 32'h14, 32'hDEAD_BEEF, 0, 0, 2);
    chk("sw14_wa", last_wa, 32'h14);
    chk("sw14_wd", last_wd, 32'hDEAD_BEEF);
    issue("lw14", 0, F3_W, 32'h14, 0, 32'hDEAD_BEEF, 0, 3);

    // Errors: no memory traffic at all
    c0 = nce; w0 = nwr;
    issue("lw12_mis", 0, F3_W,   32'h12, 0, 0, 1, 1);
    issue("sh13_mis", 1, F3_H,   32'h13, 32'h5555, 0, 1, 1);
    issue("ld011",    0, 3'b011, 32'h10, 0, 0, 1, 1);
    issue("st100",    1, F3_BU,  32'h10, 32'h77, 0, 1, 1);
    chk("err_no_ce", 32'(nce - c0), 0);
    chk("err_no_wr", 32'(nwr - w0), 0);
    chk("err_mem", mem[4], 32'hCAFE_AB80);

    // req_i held through the whole access: one response only
    wait_idle();
    r0 = nrdy;
    q.push_back('{"lw_hold", 32'hCAFE_AB80, 1'b0, 3, cyc});
    drive(0, F3_W, 32'h10, 0);
    repeat (4) @(negedge clk);
    req_i = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("hold_one_ready", 32'(nrdy - r0), 1);

    // Reset during RMW read of SB
    do_poke(4'd4, 32'h8000_7F80);
    wait_idle();
    w0 = nwr; r0 = nrdy;
    drive(1, F3_B, 32'h10, 32'h0000_0055);
    @(negedge clk);
    req_i = 1'b0;
    chk("rmw_ce_before_rst", 32'(mem_ce_o), 1);
    rst = 1'b0;
    #1;
    chk("midrst_ce", 32'(mem_ce_o), 0);
    chk("midrst_we", 32'(mem_we_o), 0);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_ready", 32'(ready_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_wr", 32'(nwr - w0), 0);
    chk("midrst_no_ready", 32'(nrdy - r0), 0);
    chk("midrst_mem", mem[4], 32'h8000_7F80);
    issue("lw10_post", 0, F3_W, 32'h10, 0, 32'h8000_7F80, 0, 3);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Load/store access controller between the riscv core's data port and data_mem.
- Core side: a req/ready handshake carrying RISC-V funct3 size and sign semantics.
- Memory side: word-only ce/we/addr/data, with no byte enables.
- Responsibilities: lane extraction with sign/zero extension for LB/LH/LW/LBU/LHU; read-modify-write for SB/SH; misalignment and illegal-funct3 detection.
- Allows the core to issue sub-word accesses against data_mem.

Parameters:
MEM_RD_LAT, 1, cycles from a read cycle (ce=1, we=0) to valid mem_rdata_i; legal values 0 or 1.
DATA_W, 32, data width; fixed at 32.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_i  input  1  access request, sampled only in IDLE
we_i  input  1  1 = store, 0 = load
funct3_i  input  3  RISC-V load/store funct3
addr_i  input  32  byte address
wdata_i  input  32  store data; low byte/half is used for SB/SH
rdata_o  output  32  extended load result, valid while ready_o=1
ready_o  output  1  one-cycle completion pulse
err_o  output  1  misaligned or illegal access, qualified by ready_o
busy_o  output  1  1 whenever state != IDLE
mem_ce_o  output  1  memory chip enable
mem_we_o  output  1  memory write enable
mem_addr_o  output  32  word-aligned byte address, {addr[31:2],2'b00}
mem_wdata_o  output  32  write word
mem_rdata_i  input  32  read word

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; latched request registers cleared; wait counter cleared.
- Request acceptance:
  - In IDLE, req_i=1 at cycle T latches we_i, funct3_i, addr_i and wdata_i.
  - req_i is ignored in any other state, including RESP.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 000 SB, 001 SH, 010 SW.
- Errors: any other funct3 is an error. H/HU with addr[0]=1, or W with addr[1:0]!=0, is misaligned.
- States: IDLE, RD, RMW_RD, WR, RESP.
- Transitions from IDLE on accept:
  - error -> RESP
  - load -> RD
  - SW -> WR
  - SB/SH -> RMW_RD
- RD / RMW_RD:
  - mem_ce_o=1, mem_we_o=0, mem_addr_o held stable.
  - Counter runs 0..MEM_RD_LAT; mem_rdata_i is captured when count == MEM_RD_LAT.
  - RD then goes to RESP; RMW_RD then goes to WR.
- WR: mem_ce_o=1 and mem_we_o=1 for exactly one cycle, then RESP.
  - SW writes wdata.
  - SB/SH writes the captured word with only the addressed byte/half lane replaced.
- RESP: ready_o=1 for one cycle, then IDLE.
  - rdata_o holds the load result, or 0 for stores and errors.
  - err_o is 1 for errors.
- Lane select uses addr[1:0]:
  - byte at bits 8*addr[1:0]+7 : 8*addr[1:0]
  - half at bits 16*addr[1]+15 : 16*addr[1]
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Latency, with ready_o asserted in the cycle shown:
  - error: T+1
  - SW: T+2
  - load: T+2+MEM_RD_LAT
  - SB/SH: T+3+MEM_RD_LAT
- Errors never assert mem_ce_o. No memory write occurs for loads or errors.
- mem_* outputs are 0 in IDLE and RESP.
- Reset mid-operation: ce/we drop immediately, so no write is committed. The request is discarded with no ready_o pulse.
- mem_rdata_i is sampled only at the capture cycle; it is a don't-care otherwise.

Decomposition:
- Shared package lsu_defs:
  - funct3 localparams: F3_B/F3_H/F3_W/F3_BU/F3_HU
  - state encoding
  - SIZE widths
- Sub-module lsu_lane_align, purely combinational:
  - inputs: funct3, addr[1:0], word, wdata
  - outputs: extended load value, merged store word, misalign/illegal flag
- The FSM, counter and request registers stay in data_mem_ctrl.

Test Plan:
All scenarios use MEM_RD_LAT=1 with mem word 0x10 = 0x8000_7F80.
1. LB addr 0x10 -> rdata_o=0xFFFF_FF80 with ready_o at T+3; LBU 0x10 -> 0x0000_0080; LB 0x11 -> 0x0000_007F.
2. LH addr 0x12 -> 0xFFFF_8000; LHU 0x12 -> 0x0000_8000; LW 0x10 -> 0x8000_7F80. mem_we_o is never 1 in any of these.
3. SB addr 0x11 wdata 0x1234_56AB -> exactly one write of 0x8000_AB80 to 0x10, ready_o at T+4; SH 0x12 wdata 0xCAFE -> word becomes 0xCAFE_AB80.
4. SW addr 0x14 wdata 0xDEAD_BEEF -> write in T+1, ready_o at T+2; LW 0x14 -> 0xDEAD_BEEF.
5. LW 0x12, SH 0x13, and funct3=011 -> err_o=1 with ready_o at T+1; mem_ce_o stays 0 throughout; memory unchanged. req_i held high during busy -> exactly one ready_o per accepted request.
6. rst pulled low in the RMW_RD cycle of SB 0x10 -> outputs 0 immediately, memory word still 0x8000_7F80, no ready_o; after release, LW 0x10 completes normally.
